// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates one entry per issued instruction, captures ALU/LSB results,
// and retires at most one ready head entry per cycle. A mispredicted conditional branch raises flush.
module reorder_buffer #(
  parameter int XLEN            = 32,
  parameter int ROB_SIZE_WIDTH  = 3,
  parameter int REG_CNT_WIDTH   = 5,
  parameter int INST_TYPE_WIDTH = 6,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_HALT = 6'd63,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_BEQ  = 6'd10,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_BNE  = 6'd11,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_BLT  = 6'd12,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_BGE  = 6'd13,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_BGEU = 6'd14,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_BLTU = 6'd15,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_SB   = 6'd20,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_SH   = 6'd21,
  parameter logic [INST_TYPE_WIDTH-1:0] INST_SW   = 6'd22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_stall,
  input  logic                       i_decoder_ready,
  input  logic [INST_TYPE_WIDTH-1:0] i_decoder_inst_type,
  input  logic [REG_CNT_WIDTH-1:0]   i_decoder_rd,
  input  logic                       i_decoder_pred_jump,
  input  logic                       i_alu_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]  i_alu_rob_id,
  input  logic [XLEN-1:0]            i_alu_val,
  input  logic                       i_alu_jump,
  input  logic [XLEN-1:0]            i_alu_target_pc,
  input  logic                       i_lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]  i_lsb_rob_id,
  input  logic [XLEN-1:0]            i_lsb_val,
  input  logic [ROB_SIZE_WIDTH-1:0]  i_qry1_id,
  input  logic [ROB_SIZE_WIDTH-1:0]  i_qry2_id,
  output logic                       o_qry1_ready,
  output logic                       o_qry2_ready,
  output logic [XLEN-1:0]            o_qry1_val,
  output logic [XLEN-1:0]            o_qry2_val,
  output logic                       o_rob_ready,
  output logic [REG_CNT_WIDTH-1:0]   o_rob_rd,
  output logic [XLEN-1:0]            o_rob_val,
  output logic [ROB_SIZE_WIDTH-1:0]  o_rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0]  o_rob_tail_id,
  output logic                       o_rob_full,
  output logic                       o_flush,
  output logic [XLEN-1:0]            o_rob_correct_pc,
  output logic                       o_rob_halt
);

  localparam int DEPTH = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0]   FULL_COUNT = (ROB_SIZE_WIDTH+1)'(DEPTH);
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_ONE    = (ROB_SIZE_WIDTH+1)'(1);
  localparam logic [ROB_SIZE_WIDTH-1:0] ID_ONE     = ROB_SIZE_WIDTH'(1);

  logic                       r_busy   [DEPTH];
  logic                       r_ready  [DEPTH];
  logic [INST_TYPE_WIDTH-1:0] r_type   [DEPTH];
  logic [REG_CNT_WIDTH-1:0]   r_rd     [DEPTH];
  logic [XLEN-1:0]            r_val    [DEPTH];
  logic                       r_pred   [DEPTH];
  logic                       r_jump   [DEPTH];
  logic [XLEN-1:0]            r_target [DEPTH];

  logic [ROB_SIZE_WIDTH-1:0]  r_head;
  logic [ROB_SIZE_WIDTH-1:0]  r_tail;
  logic [ROB_SIZE_WIDTH:0]    r_count;

  logic                       r_rob_ready;
  logic [REG_CNT_WIDTH-1:0]   r_rob_rd;
  logic [XLEN-1:0]            r_rob_val;
  logic                       r_flush;
  logic [XLEN-1:0]            r_correct_pc;
  logic                       r_halt;

  logic                       w_full;
  logic                       w_issue;
  logic                       w_commit;
  logic                       w_mispredict;
  logic                       w_head_cond;
  logic                       w_head_no_rd;
  logic                       w_lsb_wb;
  logic [ROB_SIZE_WIDTH:0]    w_count_next;

  function automatic logic is_cond_branch(input logic [INST_TYPE_WIDTH-1:0] t);
    return (t == INST_BEQ) || (t == INST_BNE) || (t == INST_BLT) ||
           (t == INST_BGE) || (t == INST_BGEU) || (t == INST_BLTU);
  endfunction

  function automatic logic is_store(input logic [INST_TYPE_WIDTH-1:0] t);
    return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
  endfunction

  assign w_full       = (r_count == FULL_COUNT);
  assign w_issue      = !i_stall && i_decoder_ready && !w_full && !r_flush && !r_halt;
  assign w_commit     = r_busy[r_head] && r_ready[r_head] && !r_halt && !r_flush;
  assign w_head_cond  = is_cond_branch(r_type[r_head]);
  assign w_head_no_rd = w_head_cond || is_store(r_type[r_head]) || (r_type[r_head] == INST_HALT);
  assign w_mispredict = w_commit && w_head_cond && (r_pred[r_head] != r_jump[r_head]);
  // ALU takes priority if both ports ever name the same entry
  assign w_lsb_wb     = i_lsb_ready && !(i_alu_ready && (i_alu_rob_id == i_lsb_rob_id));

  always_comb begin
    w_count_next = r_count;
    if (w_issue && !w_commit) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_issue && w_commit) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_rob_ready  <= 1'b0;
      r_rob_rd     <= '0;
      r_rob_val    <= '0;
      r_flush      <= 1'b0;
      r_correct_pc <= '0;
      r_halt       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i]   <= 1'b0;
        r_ready[i]  <= 1'b0;
        r_type[i]   <= '0;
        r_rd[i]     <= '0;
        r_val[i]    <= '0;
        r_pred[i]   <= 1'b0;
        r_jump[i]   <= 1'b0;
        r_target[i] <= '0;
      end
    end else begin
      r_rob_ready <= 1'b0;
      r_flush     <= 1'b0;

      if (i_alu_ready && r_busy[i_alu_rob_id]) begin
        r_ready[i_alu_rob_id]  <= 1'b1;
        r_val[i_alu_rob_id]    <= i_alu_val;
        r_jump[i_alu_rob_id]   <= i_alu_jump;
        r_target[i_alu_rob_id] <= i_alu_target_pc;
      end
      if (w_lsb_wb && r_busy[i_lsb_rob_id]) begin
        r_ready[i_lsb_rob_id] <= 1'b1;
        r_val[i_lsb_rob_id]   <= i_lsb_val;
      end

      if (w_commit && !w_mispredict) begin
        r_rob_ready     <= 1'b1;
        r_rob_rd        <= w_head_no_rd ? '0 : r_rd[r_head];
        r_rob_val       <= r_val[r_head];
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + ID_ONE;
        if (r_type[r_head] == INST_HALT) begin
          r_halt <= 1'b1;
        end
      end

      // Result fields are cleared on allocation so a HALT commit reports a clean value
      if (w_issue) begin
        r_busy[r_tail]   <= 1'b1;
        r_ready[r_tail]  <= (i_decoder_inst_type == INST_HALT);
        r_type[r_tail]   <= i_decoder_inst_type;
        r_rd[r_tail]     <= i_decoder_rd;
        r_val[r_tail]    <= '0;
        r_pred[r_tail]   <= i_decoder_pred_jump;
        r_jump[r_tail]   <= 1'b0;
        r_target[r_tail] <= '0;
        r_tail           <= r_tail + ID_ONE;
      end

      r_count <= w_count_next;

      // Mispredict squashes everything, including same-edge issue and writebacks
      if (w_mispredict) begin
        r_flush      <= 1'b1;
        r_correct_pc <= r_target[r_head];
        r_head       <= '0;
        r_tail       <= '0;
        r_count      <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
      end
    end
  end

  assign o_qry1_ready = r_busy[i_qry1_id] &&
                        (r_ready[i_qry1_id] ||
                         (i_alu_ready && (i_alu_rob_id == i_qry1_id)) ||
                         (i_lsb_ready && (i_lsb_rob_id == i_qry1_id)));
  assign o_qry1_val   = (i_alu_ready && (i_alu_rob_id == i_qry1_id)) ? i_alu_val :
                        (i_lsb_ready && (i_lsb_rob_id == i_qry1_id)) ? i_lsb_val :
                        r_val[i_qry1_id];
  assign o_qry2_ready = r_busy[i_qry2_id] &&
                        (r_ready[i_qry2_id] ||
                         (i_alu_ready && (i_alu_rob_id == i_qry2_id)) ||
                         (i_lsb_ready && (i_lsb_rob_id == i_qry2_id)));
  assign o_qry2_val   = (i_alu_ready && (i_alu_rob_id == i_qry2_id)) ? i_alu_val :
                        (i_lsb_ready && (i_lsb_rob_id == i_qry2_id)) ? i_lsb_val :
                        r_val[i_qry2_id];

  assign o_rob_ready      = r_rob_ready;
  assign o_rob_rd         = r_rob_rd;
  assign o_rob_val        = r_rob_val;
  assign o_rob_head_id    = r_head;
  assign o_rob_tail_id    = r_tail;
  assign o_rob_full       = w_full;
  assign o_flush          = r_flush;
  assign o_rob_correct_pc = r_correct_pc;
  assign o_rob_halt       = r_halt;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based
// model of the in-order buffer.
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam logic [5:0] T_ADDI = 6'd1,  T_JALR = 6'd9,  T_LW   = 6'd16, T_HALT = 6'd63;
  localparam logic [5:0] T_BEQ  = 6'd10, T_BNE  = 6'd11, T_BLT  = 6'd12, T_BGE  = 6'd13;
  localparam logic [5:0] T_BGEU = 6'd14, T_BLTU = 6'd15, T_SB   = 6'd20, T_SH   = 6'd21, T_SW = 6'd22;

  logic        clk, rst;
  logic        stall, dec_ready, dec_pred;
  logic [5:0]  dec_type;
  logic [4:0]  dec_rd;
  logic        alu_ready, alu_jump, lsb_ready;
  logic [2:0]  alu_id, lsb_id, qry1_id, qry2_id;
  logic [31:0] alu_val, alu_tgt, lsb_val;
  logic        qry1_ready, qry2_ready, rob_ready, rob_full, flush, rob_halt;
  logic [31:0] qry1_val, qry2_val, rob_val, rob_correct_pc;
  logic [4:0]  rob_rd;
  logic [2:0]  rob_head_id, rob_tail_id;

  reorder_buffer #(
    .XLEN(32), .ROB_SIZE_WIDTH(3), .REG_CNT_WIDTH(5), .INST_TYPE_WIDTH(6),
    .INST_HALT(T_HALT), .INST_BEQ(T_BEQ), .INST_BNE(T_BNE), .INST_BLT(T_BLT),
    .INST_BGE(T_BGE), .INST_BGEU(T_BGEU), .INST_BLTU(T_BLTU),
    .INST_SB(T_SB), .INST_SH(T_SH), .INST_SW(T_SW)
  ) dut (
    .clk(clk), .rst(rst), .i_stall(stall),
    .i_decoder_ready(dec_ready), .i_decoder_inst_type(dec_type), .i_decoder_rd(dec_rd),
    .i_decoder_pred_jump(dec_pred),
    .i_alu_ready(alu_ready), .i_alu_rob_id(alu_id), .i_alu_val(alu_val),
    .i_alu_jump(alu_jump), .i_alu_target_pc(alu_tgt),
    .i_lsb_ready(lsb_ready), .i_lsb_rob_id(lsb_id), .i_lsb_val(lsb_val),
    .i_qry1_id(qry1_id), .i_qry2_id(qry2_id),
    .o_qry1_ready(qry1_ready), .o_qry2_ready(qry2_ready),
    .o_qry1_val(qry1_val), .o_qry2_val(qry2_val),
    .o_rob_ready(rob_ready), .o_rob_rd(rob_rd), .o_rob_val(rob_val),
    .o_rob_head_id(rob_head_id), .o_rob_tail_id(rob_tail_id), .o_rob_full(rob_full),
    .o_flush(flush), .o_rob_correct_pc(rob_correct_pc), .o_rob_halt(rob_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-order queue of in-flight instructions, oldest first
  typedef struct {
    logic [5:0]  typ;
    logic [4:0]  rd;
    logic        pred;
    logic        done;
    logic [31:0] val;
    logic        jump;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          m_head;
  logic        m_flush, m_halt, e_ready;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_pc;

  function automatic bit is_cond(input logic [5:0] t);
    return t inside {T_BEQ, T_BNE, T_BLT, T_BGE, T_BGEU, T_BLTU};
  endfunction

  function automatic bit has_rd(input logic [5:0] t);
    return !(is_cond(t) || (t inside {T_SB, T_SH, T_SW}) || t == T_HALT);
  endfunction

  function automatic int pos_of(input int id);
    return (id - m_head + DEPTH) % DEPTH;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head = 0; m_flush = 0; m_halt = 0;
    e_ready = 0; e_rd = '0; e_val = '0; e_pc = '0;
  endtask

  task automatic model_step();
    ent_t e, t;
    int   k;
    bit   commit, misp, do_issue;
    do_issue = !stall && dec_ready && (mq.size() < DEPTH) && !m_flush && !m_halt;
    commit   = !m_flush && !m_halt && (mq.size() > 0) && mq[0].done;
    if (commit) e = mq[0];
    if (alu_ready) begin
      k = pos_of(int'(alu_id));
      if (k < mq.size()) begin
        t = mq[k]; t.done = 1; t.val = alu_val; t.jump = alu_jump; t.tgt = alu_tgt; mq[k] = t;
      end
    end
    if (lsb_ready && !(alu_ready && alu_id == lsb_id)) begin
      k = pos_of(int'(lsb_id));
      if (k < mq.size()) begin
        t = mq[k]; t.done = 1; t.val = lsb_val; mq[k] = t;
      end
    end
    misp    = commit && is_cond(e.typ) && (e.pred != e.jump);
    e_ready = commit && !misp;
    if (misp) begin
      mq.delete();
      m_head = 0;
      e_pc   = e.tgt;
    end else begin
      if (commit) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % DEPTH;
        e_rd   = has_rd(e.typ) ? e.rd : 5'd0;
        e_val  = e.val;
        if (e.typ == T_HALT) m_halt = 1;
      end
      if (do_issue) mq.push_back('{dec_type, dec_rd, dec_pred, dec_type == T_HALT, 32'd0, 1'b0, 32'd0});
    end
    m_flush = misp;
  endtask

  task automatic check_query(input string tag, input logic [2:0] id, input logic got_rdy,
                             input logic [31:0] got_val);
    int   k;
    bit   busy, ahit, lhit, exp_rdy;
    logic [31:0] exp_val;
    k    = pos_of(int'(id));
    busy = k < mq.size();
    ahit = alu_ready && alu_id == id;
    lhit = lsb_ready && lsb_id == id;
    exp_rdy = busy && (mq[k].done || ahit || lhit);
    chk({tag, "_ready"}, 32'(got_rdy), 32'(exp_rdy));
    if (exp_rdy) begin
      exp_val = ahit ? alu_val : lhit ? lsb_val : mq[k].val;
      chk({tag, "_val"}, got_val, exp_val);
    end
  endtask

  task automatic check_outputs();
    chk("rob_ready", 32'(rob_ready), 32'(e_ready));
    chk("rob_rd", 32'(rob_rd), 32'(e_rd));
    chk("rob_val", rob_val, e_val);
    chk("head_id", 32'(rob_head_id), 32'(m_head));
    chk("tail_id", 32'(rob_tail_id), 32'((m_head + mq.size()) % DEPTH));
    chk("rob_full", 32'(rob_full), 32'(mq.size() == DEPTH));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("correct_pc", rob_correct_pc, e_pc);
    chk("rob_halt", 32'(rob_halt), 32'(m_halt));
  endtask

  task automatic idle();
    stall = 0; dec_ready = 0; dec_type = '0; dec_rd = '0; dec_pred = 0;
    alu_ready = 0; alu_id = '0; alu_val = '0; alu_jump = 0; alu_tgt = '0;
    lsb_ready = 0; lsb_id = '0; lsb_val = '0; qry1_id = '0; qry2_id = '0;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic step();
    #1;
    check_query("qry1", qry1_id, qry1_ready, qry1_val);
    check_query("qry2", qry2_id, qry2_ready, qry2_val);
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    idle();
  endtask

  // Asserts reset between edges; outputs must clear without waiting for a clock
  task automatic reset_mid();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_rob_ready", 32'(rob_ready), 32'd0);
    chk("rst_rob_rd", 32'(rob_rd), 32'd0);
    chk("rst_rob_val", rob_val, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_correct_pc", rob_correct_pc, 32'd0);
    chk("rst_halt", 32'(rob_halt), 32'd0);
    chk("rst_head", 32'(rob_head_id), 32'd0);
    chk("rst_tail", 32'(rob_tail_id), 32'd0);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_qry1", 32'(qry1_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [5:0] typ, input logic [4:0] rd, input logic pred);
    dec_ready = 1; dec_type = typ; dec_rd = rd; dec_pred = pred;
    step();
  endtask

  task automatic alu_wb(input logic [2:0] id, input logic [31:0] v, input logic j, input logic [31:0] tg);
    alu_ready = 1; alu_id = id; alu_val = v; alu_jump = j; alu_tgt = tg;
    step();
  endtask

  function automatic logic [2:0] pick_id();
    if (mq.size() > 0 && $urandom_range(3, 0) != 0)
      return 3'((m_head + int'($urandom_range(mq.size() - 1, 0))) % DEPTH);
    return 3'($urandom_range(DEPTH - 1, 0));
  endfunction

  logic [5:0] kinds [10];
  int         k;

  initial begin
    kinds = '{T_ADDI, T_LW, T_SW, T_SB, T_SH, T_BEQ, T_BNE, T_BLT, T_BGEU, T_JALR};
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);

    // Single ADDI: writeback then commit one cycle later
    reset_mid();
    issue(T_ADDI, 5'd5, 1'b0);
    alu_wb(3'd0, 32'h2A, 1'b0, 32'h0);
    chk("s1_no_early_commit", 32'(rob_ready), 32'd0);
    step();
    chk("s1_ready", 32'(rob_ready), 32'd1);
    chk("s1_rd", 32'(rob_rd), 32'd5);
    chk("s1_val", rob_val, 32'h2A);
    chk("s1_head", 32'(rob_head_id), 32'd1);

    // Fill to capacity, a ninth issue is ignored, then drain one
    reset_mid();
    for (int i = 0; i < 8; i++) issue(T_ADDI, 5'(i + 1), 1'b0);
    chk("s2_full", 32'(rob_full), 32'd1);
    chk("s2_tail_wrap", 32'(rob_tail_id), 32'd0);
    issue(T_ADDI, 5'd31, 1'b0);
    chk("s2_ninth_ignored", 32'(rob_tail_id), 32'd0);
    alu_wb(3'd0, 32'h7, 1'b0, 32'h0);
    chk("s2_still_full", 32'(rob_full), 32'd1);
    step();
    chk("s2_commit", 32'(rob_ready), 32'd1);
    chk("s2_full_drop", 32'(rob_full), 32'd0);

    // Out-of-order writeback, in-order commit
    reset_mid();
    for (int i = 0; i < 3; i++) issue(T_ADDI, 5'(i + 10), 1'b0);
    alu_wb(3'd2, 32'd3, 1'b0, 32'h0);
    alu_wb(3'd1, 32'd2, 1'b0, 32'h0);
    alu_wb(3'd0, 32'd1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_order_ready", 32'(rob_ready), 32'd1);
      chk("s3_order_val", rob_val, 32'(i + 1));
    end

    // Mispredicted BEQ squashes the younger ADDI
    reset_mid();
    issue(T_BEQ, 5'd3, 1'b0);
    issue(T_ADDI, 5'd7, 1'b0);
    alu_wb(3'd0, 32'h0, 1'b1, 32'h1000);
    step();
    chk("s4_flush", 32'(flush), 32'd1);
    chk("s4_pc", rob_correct_pc, 32'h1000);
    chk("s4_head", 32'(rob_head_id), 32'd0);
    chk("s4_tail", 32'(rob_tail_id), 32'd0);
    chk("s4_no_commit", 32'(rob_ready), 32'd0);
    issue(T_ADDI, 5'd4, 1'b0);
    chk("s4_flush_one_cycle", 32'(flush), 32'd0);
    chk("s4_issue_blocked", 32'(rob_tail_id), 32'd0);

    // Query bypass from a same-cycle ALU writeback
    reset_mid();
    for (int i = 0; i < 4; i++) issue(T_ADDI, 5'(i + 1), 1'b0);
    alu_ready = 1; alu_id = 3'd3; alu_val = 32'h55; qry1_id = 3'd3;
    #1;
    chk("s5_qry_ready", 32'(qry1_ready), 32'd1);
    chk("s5_qry_val", qry1_val, 32'h55);
    step();

    // SW then HALT commit in order; halt is sticky
    reset_mid();
    issue(T_SW, 5'd3, 1'b0);
    issue(T_HALT, 5'd9, 1'b0);
    lsb_ready = 1; lsb_id = 3'd0; lsb_val = 32'hDEAD;
    step();
    step();
    chk("s6_sw_commit", 32'(rob_ready), 32'd1);
    chk("s6_sw_rd", 32'(rob_rd), 32'd0);
    step();
    chk("s6_halt_commit", 32'(rob_ready), 32'd1);
    chk("s6_halt", 32'(rob_halt), 32'd1);
    issue(T_ADDI, 5'd1, 1'b0);
    chk("s6_halt_sticky", 32'(rob_halt), 32'd1);
    chk("s6_no_issue", 32'(rob_tail_id), 32'd2);
    reset_mid();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      stall     = ($urandom_range(7, 0) == 0);
      dec_ready = $urandom_range(1, 0);
      dec_type  = ($urandom_range(99, 0) == 0) ? T_HALT : kinds[$urandom_range(9, 0)];
      dec_rd    = 5'($urandom);
      dec_pred  = $urandom_range(1, 0);
      if ($urandom_range(1, 0) != 0) begin
        alu_ready = 1; alu_id = pick_id(); alu_val = $urandom;
        alu_jump = $urandom_range(1, 0); alu_tgt = $urandom;
      end
      if ($urandom_range(1, 0) != 0) begin
        lsb_id  = pick_id();
        lsb_val = $urandom;
        k = pos_of(int'(lsb_id));
        lsb_ready = !(k < mq.size() && is_cond(mq[k].typ));
      end
      qry1_id = 3'($urandom);
      qry2_id = pick_id();
      step();
      if ((m_halt && $urandom_range(3, 0) == 0) || $urandom_range(299, 0) == 0) reset_mid();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular in-order commit buffer between decode/issue and the architectural register file. It allocates one entry per issued instruction and captures results from the ALU and LSB writeback ports. It retires at most one ready head entry per cycle, presenting the commit to the register file. On a mispredicted conditional branch it raises the global flush.

Parameters:
XLEN, 32, data width
ROB_SIZE_WIDTH, 3, log2 of entry count (8 entries)
REG_CNT_WIDTH, 5, register index width
INST_TYPE_WIDTH, 6, instruction-type code width (global encodings, incl. HALT, BEQ..BLTU, SB/SH/SW)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall  in  1  global stall; blocks issue only
decoder_ready  in  1  instruction presented for issue
decoder_inst_type  in  INST_TYPE_WIDTH  instruction type
decoder_rd  in  REG_CNT_WIDTH  destination register
decoder_pred_jump  in  1  predicted taken (branches)
alu_ready  in  1  ALU result valid
alu_rob_id  in  ROB_SIZE_WIDTH  target entry
alu_val  in  XLEN  result
alu_jump  in  1  actual branch outcome
alu_target_pc  in  XLEN  correct next PC for branches
lsb_ready  in  1  load/store completion valid
lsb_rob_id  in  ROB_SIZE_WIDTH  target entry
lsb_val  in  XLEN  load data (don't-care for stores)
qry1_id, qry2_id  in  ROB_SIZE_WIDTH  operand lookup ids
qry1_ready, qry2_ready  out  1  entry result available
qry1_val, qry2_val  out  XLEN  entry result
rob_ready  out  1  commit valid this cycle (registered)
rob_rd  out  REG_CNT_WIDTH  committed rd (0 for branch/store/halt)
rob_val  out  XLEN  committed value
rob_head_id  out  ROB_SIZE_WIDTH  head pointer, already advanced past the committed entry
rob_tail_id  out  ROB_SIZE_WIDTH  id the next issued instruction receives
rob_full  out  1  count == 2^ROB_SIZE_WIDTH
flush  out  1  one-cycle mispredict flush (registered)
rob_correct_pc  out  XLEN  redirect PC, valid with flush
rob_halt  out  1  sticky; HALT committed

Behaviour:
- State: head, tail (ROB_SIZE_WIDTH, wrap modulo 2^ROB_SIZE_WIDTH), count (ROB_SIZE_WIDTH+1 bits). Per entry: busy, ready, inst_type, rd, val, pred_jump, actual_jump, target_pc.
- Reset (async): head=tail=count=0; all busy/ready=0; rob_ready, rob_rd, rob_val, flush, rob_correct_pc, rob_halt=0. Reset mid-operation discards all entries immediately.
- Issue: when !stall && decoder_ready && !rob_full && !flush && !rob_halt, fill entry[tail] with busy=1 and ready=(type==HALT); tail++, count++. rob_full blocks issue even if a commit occurs in the same cycle.
- Writeback: on alu_ready/lsb_ready, if entry[id].busy, set ready=1 and store val, and from the ALU also actual_jump and target_pc. Writebacks to non-busy entries are ignored. ALU and LSB never target the same id in one cycle; if they do, ALU wins.
- Query (combinational): qryN_ready = entry busy && (ready || same-cycle ALU/LSB writeback to that id); value bypassed from the writeback port when it is writing.
- Commit: at posedge, if entry[head].busy && ready && !rob_halt, then rob_ready<=1, rob_rd<=rd (forced 0 for branch/store/HALT types), rob_val<=val, busy<=0, head++, count--. Otherwise rob_ready<=0. No same-cycle writeback-to-commit bypass: the earliest commit is 1 cycle after writeback.
- Simultaneous issue and commit: count unchanged.
- HALT commit: rob_halt<=1 (sticky until rst); all further commits and issues stop.
- Mispredict: committing a conditional branch with pred_jump != actual_jump sets flush<=1 and rob_correct_pc<=target_pc. On the same edge all entries are cleared and head=tail=count=0. flush is high for exactly one cycle; issue and commit are suppressed in that cycle. rob_ready is 0 during flush. JALR never mispredicts here because decode stalls it.
- Correct branch commit: rob_ready=1, rob_rd=0, no flush.

Test Plan:
- Reset then issue ADDI rd=5 (id 0); ALU writes id0 val 0x2A at cycle N -> commit at N+1: rob_ready=1, rob_rd=5, rob_val=0x2A, rob_head_id=1.
- Issue 8 instructions with no writeback -> rob_full=1, 9th decoder_ready ignored, rob_tail_id=0 (wrapped); writeback id0 -> commit, rob_full drops next cycle.
- Out-of-order writeback to ids 2,1,0 with vals 3,2,1 -> three consecutive commits in id order with vals 1,2,3.
- BEQ pred_jump=0, ALU alu_jump=1, target 0x1000 -> flush=1 for one cycle, rob_correct_pc=0x1000, head=tail=0, younger entries discarded, rob_ready=0.
- Query id3 in the same cycle as ALU writeback id3 val 0x55 -> qry1_ready=1, qry1_val=0x55 combinationally.
- Issue HALT after SW -> both commit in order; rob_halt=1 sticky; assert rst mid-stream -> all outputs 0 immediately.
